hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 25 ++
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_stall_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        RELEASE  = 2'd2
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO            = 5'd0;
    localparam int unsigned MDU_TIMEOUT_DEFAULT = 64;

    // Load in EX whose destination feeds a source operand of the instruction in ID.
    function automatic logic load_use_hit(
        input logic       ex_ren,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_ren && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async reset and sync clear.
// Only built when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/hazard_stall_ctrl.sv
// IF/ID and ID/EX sequencing: load-use stall, MDU freeze, branch flush.
// Optional STALL_CNT/FLUSH_CNT performance counters under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_TIMEOUT = MDU_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ID_RS,
    input  logic [4:0]       ID_RT,
    input  logic             ID_UsesRT,
    input  logic             ID_MDU_START,
    input  logic             EX_MEM_REN,
    input  logic [4:0]       EX_RT,
    input  logic             EX_BranchTaken,
    input  logic             MDU_DONE,
    output logic             PC_WEN,
    output logic             IF_ID_WEN,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_BUBBLE,
    output logic             MDU_GO,
    output logic             MDU_ABORT,
    output logic             MDU_TIMEOUT_ERR,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam int unsigned         WCNT_W    = $clog2(MDU_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0]   WAIT_LAST = WCNT_W'(MDU_TIMEOUT - 1);

    hz_state_t         state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              err_set;
    logic              load_use;

    assign load_use = load_use_hit(EX_MEM_REN, EX_RT, ID_RS, ID_RT, ID_UsesRT);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_set      = 1'b0;
        PC_WEN       = 1'b1;
        IF_ID_WEN    = 1'b1;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_BUBBLE = 1'b0;
        MDU_GO       = 1'b0;
        MDU_ABORT    = 1'b0;

        case (state)
            RUN: begin
                if (EX_BranchTaken) begin
                    IF_ID_FLUSH  = 1'b1;
                    ID_EX_BUBBLE = 1'b1;
                end else if (load_use) begin
                    PC_WEN       = 1'b0;
                    IF_ID_WEN    = 1'b0;
                    ID_EX_BUBBLE = 1'b1;
                end else if (ID_MDU_START) begin
                    MDU_GO       = 1'b1;
                    PC_WEN       = 1'b0;
                    IF_ID_WEN    = 1'b0;
                    ID_EX_BUBBLE = 1'b1;
                    state_nxt    = MDU_WAIT;
                    wait_cnt_nxt = '0;
                end
            end

            MDU_WAIT: begin
                PC_WEN       = 1'b0;
                IF_ID_WEN    = 1'b0;
                ID_EX_BUBBLE = 1'b1;
                if (wait_cnt != '1) begin
                    wait_cnt_nxt = wait_cnt + WCNT_W'(1);
                end
                // A taken branch kills the MDU instruction, so it beats both done and timeout.
                if (EX_BranchTaken) begin
                    PC_WEN      = 1'b1;
                    IF_ID_WEN   = 1'b1;
                    IF_ID_FLUSH = 1'b1;
                    MDU_ABORT   = 1'b1;
                    state_nxt   = RUN;
                end else if (MDU_DONE) begin
                    state_nxt = RELEASE;
                end else if (wait_cnt == WAIT_LAST) begin
                    MDU_ABORT = 1'b1;
                    err_set   = 1'b1;
                    state_nxt = RUN;
                end
            end

            RELEASE: begin
                state_nxt = RUN;
                if (EX_BranchTaken) begin
                    IF_ID_FLUSH  = 1'b1;
                    ID_EX_BUBBLE = 1'b1;
                end
            end

            default: begin
                state_nxt = RUN;
            end
        endcase

        if (reset) begin
            PC_WEN       = 1'b0;
            IF_ID_WEN    = 1'b0;
            IF_ID_FLUSH  = 1'b0;
            ID_EX_BUBBLE = 1'b1;
            MDU_GO       = 1'b0;
            MDU_ABORT    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= RUN;
            wait_cnt        <= '0;
            MDU_TIMEOUT_ERR <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (err_set) begin
                MDU_TIMEOUT_ERR <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (!PC_WEN),
        .value (STALL_CNT)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (IF_ID_FLUSH),
        .value (FLUSH_CNT)
    );
`else
    assign STALL_CNT = '0;
    assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: two controllers (timeout 64 and 8) against a rule-level model.
// Counter checks follow HAZARD_PERF_CNT_EN.
module tb_hazard_stall_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       uses_rt = 1'b0, start = 1'b0, ex_ren = 1'b0, br = 1'b0, done = 1'b0;

    logic        pc_wen[2], if_wen[2], if_flush[2], bubble[2], go[2], abort[2], err[2];
    logic [15:0] stall_cnt[2], flush_cnt[2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    hazard_stall_ctrl #(.MDU_TIMEOUT(64), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .ID_RS(id_rs), .ID_RT(id_rt), .ID_UsesRT(uses_rt),
        .ID_MDU_START(start), .EX_MEM_REN(ex_ren), .EX_RT(ex_rt), .EX_BranchTaken(br),
        .MDU_DONE(done), .PC_WEN(pc_wen[0]), .IF_ID_WEN(if_wen[0]), .IF_ID_FLUSH(if_flush[0]),
        .ID_EX_BUBBLE(bubble[0]), .MDU_GO(go[0]), .MDU_ABORT(abort[0]),
        .MDU_TIMEOUT_ERR(err[0]), .STALL_CNT(stall_cnt[0]), .FLUSH_CNT(flush_cnt[0])
    );

    hazard_stall_ctrl #(.MDU_TIMEOUT(8), .CNT_W(16)) dut_b (
        .clock(clock), .reset(reset), .ID_RS(id_rs), .ID_RT(id_rt), .ID_UsesRT(uses_rt),
        .ID_MDU_START(start), .EX_MEM_REN(ex_ren), .EX_RT(ex_rt), .EX_BranchTaken(br),
        .MDU_DONE(done), .PC_WEN(pc_wen[1]), .IF_ID_WEN(if_wen[1]), .IF_ID_FLUSH(if_flush[1]),
        .ID_EX_BUBBLE(bubble[1]), .MDU_GO(go[1]), .MDU_ABORT(abort[1]),
        .MDU_TIMEOUT_ERR(err[1]), .STALL_CNT(stall_cnt[1]), .FLUSH_CNT(flush_cnt[1])
    );

    // ---------------- reference model ----------------
    // waited: -1 when no MDU op is outstanding, else wait cycles already spent on it.
    typedef struct packed {
        logic pc, ifw, fl, bub, go, ab, set_err;
        int   n_wait;
        logic n_rel;
    } exp_t;

    int   tmo[2]     = '{64, 8};
    int   m_wait[2]  = '{-1, -1};
    logic m_rel[2]   = '{1'b0, 1'b0};
    logic m_err[2]   = '{1'b0, 1'b0};
    int   m_stall[2] = '{0, 0};
    int   m_flush[2] = '{0, 0};

    function automatic exp_t predict(input int waited, input logic rel, input int t);
        exp_t e;
        logic lu;
        lu = ex_ren && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
        e = '{pc: 1'b1, ifw: 1'b1, fl: 1'b0, bub: 1'b0, go: 1'b0, ab: 1'b0, set_err: 1'b0,
              n_wait: -1, n_rel: 1'b0};
        if (reset) begin
            e.pc = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
        end else if (waited >= 0) begin
            if (br) begin
                e.fl = 1'b1; e.bub = 1'b1; e.ab = 1'b1;
            end else begin
                e.pc = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
                if (done)                 e.n_rel = 1'b1;
                else if (waited == t - 1) begin e.ab = 1'b1; e.set_err = 1'b1; end
                else                      e.n_wait = waited + 1;
            end
        end else if (br) begin
            e.fl = 1'b1; e.bub = 1'b1;
        end else if (rel) begin
            // instruction leaves ID: plain advance
        end else if (lu) begin
            e.pc = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
        end else if (start) begin
            e.pc = 1'b0; e.ifw = 1'b0; e.bub = 1'b1; e.go = 1'b1; e.n_wait = 0;
        end
        return e;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_wait[i]  <= -1;
                m_rel[i]   <= 1'b0;
                m_err[i]   <= 1'b0;
                m_stall[i] <= 0;
                m_flush[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                e = predict(m_wait[i], m_rel[i], tmo[i]);
                m_wait[i] <= e.n_wait;
                m_rel[i]  <= e.n_rel;
                if (e.set_err) m_err[i] <= 1'b1;
                if (!e.pc && m_stall[i] < 65535) m_stall[i] <= m_stall[i] + 1;
                if (e.fl && m_flush[i] < 65535)  m_flush[i] <= m_flush[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return (v == v) ? 0 : 0;
`endif
    endfunction

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                e = predict(m_wait[i], m_rel[i], tmo[i]);
                chk("pc_wen",    i, 32'(pc_wen[i]),   32'(e.pc));
                chk("if_id_wen", i, 32'(if_wen[i]),   32'(e.ifw));
                chk("flush",     i, 32'(if_flush[i]), 32'(e.fl));
                chk("bubble",    i, 32'(bubble[i]),   32'(e.bub));
                chk("mdu_go",    i, 32'(go[i]),       32'(e.go));
                chk("mdu_abort", i, 32'(abort[i]),    32'(e.ab));
                chk("tmo_err",   i, 32'(err[i]),      32'(m_err[i]));
                chk("stall_cnt", i, 32'(stall_cnt[i]), cnt_exp(m_stall[i]));
                chk("flush_cnt", i, 32'(flush_cnt[i]), cnt_exp(m_flush[i]));
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        uses_rt = 1'b0; start = 1'b0; ex_ren = 1'b0; br = 1'b0; done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        next();
        reset = 1'b0;
    endtask

    logic [31:0] lit_stall_mdu;
    logic [31:0] lit_flush_one;

    initial begin
`ifdef HAZARD_PERF_CNT_EN
        lit_stall_mdu = 32'd11;
        lit_flush_one = 32'd1;
`else
        lit_stall_mdu = 32'd0;
        lit_flush_one = 32'd0;
`endif
        #2;
        chk("L_rst_pc",     0, 32'(pc_wen[0]), 0);
        chk("L_rst_bubble", 0, 32'(bubble[0]), 1);
        chk("L_rst_ifwen",  1, 32'(if_wen[1]), 0);
        next();
        next();
        reset = 1'b0;

        // load-use on rs: exactly one stall cycle
        ex_ren = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        at_neg();
        chk("L_lu_pc",     0, 32'(pc_wen[0]), 0);
        chk("L_lu_ifwen",  0, 32'(if_wen[0]), 0);
        chk("L_lu_bubble", 0, 32'(bubble[0]), 1);
        next();
        ex_ren = 1'b0;
        at_neg();
        chk("L_lu_after_pc", 0, 32'(pc_wen[0]), 1);
        chk("L_lu_after_bb", 0, 32'(bubble[0]), 0);
        next();

        // EX_RT==0 never hazards
        ex_ren = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        at_neg();
        chk("L_r0_pc", 0, 32'(pc_wen[0]), 1);
        next();
        // rt match only counts when rt is a source
        ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; uses_rt = 1'b0;
        at_neg();
        chk("L_rt_unused_pc", 0, 32'(pc_wen[0]), 1);
        next();
        uses_rt = 1'b1;
        at_neg();
        chk("L_rt_used_pc", 0, 32'(pc_wen[0]), 0);
        next();
        clear_inputs();
        next();

        // MDU op, done on the 10th wait cycle
        do_reset();
        start = 1'b1;
        at_neg();
        chk("L_mdu_go", 0, 32'(go[0]), 1);
        chk("L_mdu_pc", 0, 32'(pc_wen[0]), 0);
        next();
        for (int k = 1; k <= 10; k++) begin
            done = (k == 10);
            at_neg();
            chk("L_wait_pc", 0, 32'(pc_wen[0]), 0);
            chk("L_wait_go", 0, 32'(go[0]), 0);
            next();
            done = 1'b0;
        end
        at_neg();
        chk("L_rel_bubble", 0, 32'(bubble[0]), 0);
        chk("L_rel_pc",     0, 32'(pc_wen[0]), 1);
        chk("L_rel_go",     0, 32'(go[0]), 0);
        next();
        start = 1'b0;
        at_neg();
        chk("L_mdu_stallcnt", 0, 32'(stall_cnt[0]), lit_stall_mdu);
        chk("L_run_pc",       0, 32'(pc_wen[0]), 1);
        next();

        // timeout on the 8-cycle instance; the 64-cycle one keeps waiting
        do_reset();
        start = 1'b1;
        at_neg();
        next();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            at_neg();
            chk("L_to_pc", 1, 32'(pc_wen[1]), 0);
            if (k == 8) begin
                chk("L_to_abort", 1, 32'(abort[1]), 1);
                chk("L_to_err0",  1, 32'(err[1]), 0);
            end else begin
                chk("L_to_noabort", 1, 32'(abort[1]), 0);
            end
            next();
        end
        at_neg();
        chk("L_to_err1",   1, 32'(err[1]), 1);
        chk("L_to_run_pc", 1, 32'(pc_wen[1]), 1);
        chk("L_to_a_wait", 0, 32'(pc_wen[0]), 0);
        repeat (3) next();
        at_neg();
        chk("L_to_sticky", 1, 32'(err[1]), 1);
        next();
        // branch while waiting aborts and flushes
        br = 1'b1;
        at_neg();
        chk("L_brw_abort", 0, 32'(abort[0]), 1);
        chk("L_brw_flush", 0, 32'(if_flush[0]), 1);
        chk("L_brw_pc",    0, 32'(pc_wen[0]), 1);
        chk("L_brw_bb",    0, 32'(bubble[0]), 1);
        chk("L_brr_abort", 1, 32'(abort[1]), 0);
        chk("L_brr_flush", 1, 32'(if_flush[1]), 1);
        next();
        br = 1'b0;
        at_neg();
        chk("L_brw_after_pc", 0, 32'(pc_wen[0]), 1);
        chk("L_brw_no_err",   0, 32'(err[0]), 0);
        next();

        // branch beats load-use and MDU start
        do_reset();
        br = 1'b1; ex_ren = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; start = 1'b1;
        at_neg();
        chk("L_br_go",    0, 32'(go[0]), 0);
        chk("L_br_flush", 0, 32'(if_flush[0]), 1);
        chk("L_br_pc",    0, 32'(pc_wen[0]), 1);
        chk("L_br_ifwen", 0, 32'(if_wen[0]), 1);
        next();
        clear_inputs();
        at_neg();
        chk("L_br_flushcnt", 0, 32'(flush_cnt[0]), lit_flush_one);
        chk("L_br_run_pc",   0, 32'(pc_wen[0]), 1);
        next();

        // async reset on wait cycle 3
        do_reset();
        start = 1'b1;
        at_neg();
        next();
        start = 1'b0;
        next();
        next();
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("L_ar_pc",     i, 32'(pc_wen[i]), 0);
            chk("L_ar_ifwen",  i, 32'(if_wen[i]), 0);
            chk("L_ar_bubble", i, 32'(bubble[i]), 1);
            chk("L_ar_abort",  i, 32'(abort[i]), 0);
            chk("L_ar_go",     i, 32'(go[i]), 0);
        end
        next();
        #2;
        reset = 1'b0;
        at_neg();
        chk("L_ar_after_pc", 0, 32'(pc_wen[0]), 1);
        chk("L_ar_after_bb", 0, 32'(bubble[0]), 0);
        chk("L_ar_after_pc", 1, 32'(pc_wen[1]), 1);
        next();
        repeat (3) next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
